// File: rtl/aes_pkg.sv
// Shared AES datapath types and sizing helpers.
//   AES_WORD_W / AES_BLOCK_WORDS : default word width and words per block
//   aes_word_t / aes_block_t     : one 32-bit word, one 128-bit state/key block
//   ser_state_e                  : word_serializer control states
//   idx_width()                  : index width for an N-entry select, never below 1
package aes_pkg;

  localparam int unsigned AES_WORD_W      = 32;
  localparam int unsigned AES_BLOCK_WORDS = 4;
  localparam int unsigned AES_BLOCK_W     = AES_WORD_W * AES_BLOCK_WORDS;

  typedef logic [AES_WORD_W-1:0]  aes_word_t;
  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ser_state_e;

  // A 1-entry select still needs a 1-bit index port.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/word_serializer_word_select.sv
// word_select: combinational NUM_WORDS:1 word picker.
//   block_i : packed block, word k = block_i[BLOCK_W-1-k*WORD_W -: WORD_W] (k=0 is MSW)
//   idx_i   : word number k to select
//   word_o  : selected word; zero for an out-of-range index
module word_select
  import aes_pkg::*;
#(
  parameter int unsigned WORD_W    = AES_WORD_W,
  parameter int unsigned NUM_WORDS = AES_BLOCK_WORDS,
  parameter int unsigned BLOCK_W   = WORD_W * NUM_WORDS,
  parameter int unsigned IDX_W     = idx_width(NUM_WORDS)
) (
  input  logic [BLOCK_W-1:0] block_i,
  input  logic [IDX_W-1:0]   idx_i,
  output logic [WORD_W-1:0]  word_o
);

  // One-hot style compare per word keeps this a flat AND-OR mux.
  always_comb begin
    word_o = '0;
    for (int unsigned k = 0; k < NUM_WORDS; k++) begin
      if (idx_i == IDX_W'(k)) begin
        word_o = block_i[BLOCK_W-1-k*WORD_W -: WORD_W];
      end
    end
  end

endmodule

// File: rtl/word_serializer.sv
// word_serializer: latches one wide block and streams it out word by word.
//   clk, rst_n    : rising-edge clock, asynchronous active-low reset
//   in_valid      : block offered on in_data
//   in_ready      : block accepted this cycle when in_valid is high (combinational)
//   in_data       : block, word 0 in the most significant slice
//   in_lsw_first  : order mode sampled with the block (1 = last word first)
//   out_valid     : out_data holds a word (registered)
//   out_ready     : consumer takes the word this cycle
//   out_data      : current word (registered)
//   out_idx       : word number of out_data within the block (registered)
//   out_last      : out_data is the final word of the block (registered)
module word_serializer
  import aes_pkg::*;
#(
  parameter int unsigned WORD_W    = AES_WORD_W,
  parameter int unsigned NUM_WORDS = AES_BLOCK_WORDS,
  parameter int unsigned BLOCK_W   = WORD_W * NUM_WORDS,
  parameter int unsigned IDX_W     = idx_width(NUM_WORDS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic               in_lsw_first,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_data,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last
);

  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(NUM_WORDS - 1);

  ser_state_e         state_q, state_d;
  logic [BLOCK_W-1:0] block_q, block_d;
  logic               mode_q, mode_d;
  logic [IDX_W-1:0]   count_q, count_d;
  logic               out_valid_q, out_valid_d;
  logic [WORD_W-1:0]  out_data_q, out_data_d;
  logic [IDX_W-1:0]   out_idx_q, out_idx_d;
  logic               out_last_q, out_last_d;

  logic               xfer_c;
  logic               done_c;
  logic               load_c;
  logic [IDX_W-1:0]   sel_idx_d;
  logic [WORD_W-1:0]  sel_word_c;

  // Handshake qualifiers; a finishing block frees the input in the same cycle.
  assign xfer_c   = out_valid_q && out_ready;
  assign done_c   = xfer_c && out_last_q;
  assign in_ready = (state_q == IDLE) || done_c;
  assign load_c   = in_valid && in_ready;

  // Next-state: load wins over finish so back-to-back blocks have no bubble.
  always_comb begin
    state_d = state_q;
    block_d = block_q;
    mode_d  = mode_q;
    count_d = count_q;
    if (load_c) begin
      state_d = BUSY;
      block_d = in_data;
      mode_d  = in_lsw_first;
      count_d = '0;
    end else if (done_c) begin
      state_d = IDLE;
      count_d = '0;
    end else if (xfer_c) begin
      count_d = count_q + IDX_W'(1);
    end
  end

  // Output next-state, computed from the next block/count so outputs stay registered.
  always_comb begin
    out_valid_d = (state_d == BUSY);
    sel_idx_d   = mode_d ? (LAST_CNT - count_d) : count_d;
    out_idx_d   = out_valid_d ? sel_idx_d : '0;
    out_last_d  = out_valid_d && (count_d == LAST_CNT);
  end

  word_select #(
    .WORD_W   (WORD_W),
    .NUM_WORDS(NUM_WORDS),
    .BLOCK_W  (BLOCK_W),
    .IDX_W    (IDX_W)
  ) u_word_select (
    .block_i(block_d),
    .idx_i  (sel_idx_d),
    .word_o (sel_word_c)
  );

  // Idle output word is forced to zero.
  assign out_data_d = out_valid_d ? sel_word_c : '0;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      block_q     <= '0;
      mode_q      <= 1'b0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      block_q     <= block_d;
      mode_q      <= mode_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: three configurations (32x4, 8x1, 8x16) checked
// against a queue-of-expected-words model plus directed literal checks.
module tb_word_serializer;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  logic clk, rst_n;

  logic         iv0, ir0, m0, ov0, or0, ol0;
  logic [127:0] d0;
  logic [31:0]  od0;
  logic [1:0]   oi0;

  logic         iv1, ir1, m1, ov1, or1, ol1;
  logic [7:0]   d1, od1;
  logic [0:0]   oi1;

  logic         iv2, ir2, m2, ov2, or2, ol2;
  logic [127:0] d2;
  logic [7:0]   od2;
  logic [3:0]   oi2;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  bit          rnd_done = 1'b0;

  exp_t q0[$], q1[$], q2[$];
  exp_t f0, f1, f2;
  bit   r0, r1, r2;

  logic [127:0] blk_a, blk_b;
  logic [31:0]  aw[4];
  logic [31:0]  bw[4];

  word_serializer #(.WORD_W(32), .NUM_WORDS(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_data(d0),
    .in_lsw_first(m0), .out_valid(ov0), .out_ready(or0), .out_data(od0),
    .out_idx(oi0), .out_last(ol0));

  word_serializer #(.WORD_W(8), .NUM_WORDS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_data(d1),
    .in_lsw_first(m1), .out_valid(ov1), .out_ready(or1), .out_data(od1),
    .out_idx(oi1), .out_last(ol1));

  word_serializer #(.WORD_W(8), .NUM_WORDS(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .in_data(d2),
    .in_lsw_first(m2), .out_valid(ov2), .out_ready(or2), .out_data(od2),
    .out_idx(oi2), .out_last(ol2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Word k of a block counted from the most significant end, by shifting.
  function automatic logic [31:0] word_of(input logic [127:0] blk, input int w,
                                          input int nw, input int k);
    logic [127:0] s;
    s = blk >> ((nw - 1 - k) * w);
    return 32'(s & ((128'd1 << w) - 128'd1));
  endfunction

  // The c-th word emitted for a block in the given order mode.
  function automatic exp_t mk(input logic [127:0] blk, input int w, input int nw,
                              input logic mode, input int c);
    exp_t e;
    int k;
    k = mode ? (nw - 1 - c) : c;
    e.data = word_of(blk, w, nw, k);
    e.idx  = 4'(k);
    e.last = (c == nw - 1);
    return e;
  endfunction

  // Model: a block expands into its word sequence when accepted; a word leaves on out_ready.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0.delete(); q1.delete(); q2.delete();
    end else begin
      r0 = (q0.size() == 0) || (q0.size() == 1 && or0);
      r1 = (q1.size() == 0) || (q1.size() == 1 && or1);
      r2 = (q2.size() == 0) || (q2.size() == 1 && or2);
      if (q0.size() > 0 && or0) void'(q0.pop_front());
      if (q1.size() > 0 && or1) void'(q1.pop_front());
      if (q2.size() > 0 && or2) void'(q2.pop_front());
      if (iv0 && r0) for (int c = 0; c < 4; c++)  q0.push_back(mk(d0, 32, 4, m0, c));
      if (iv1 && r1) for (int c = 0; c < 1; c++)  q1.push_back(mk(128'(d1), 8, 1, m1, c));
      if (iv2 && r2) for (int c = 0; c < 16; c++) q2.push_back(mk(d2, 8, 16, m2, c));
    end
  end

  task automatic cmp(input string t, input int sz, input logic ov, input logic ir,
                     input logic orr, input logic [31:0] od, input logic [3:0] oi,
                     input logic ol, input exp_t f);
    chk({t, " out_valid"}, 128'(ov), 128'(sz > 0));
    chk({t, " in_ready"}, 128'(ir), 128'((sz == 0) || (sz == 1 && orr)));
    if (sz > 0) begin
      chk({t, " out_data"}, 128'(od), 128'(f.data));
      chk({t, " out_idx"}, 128'(oi), 128'(f.idx));
      chk({t, " out_last"}, 128'(ol), 128'(f.last));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (q0.size() > 0) f0 = q0[0]; else f0 = '0;
      if (q1.size() > 0) f1 = q1[0]; else f1 = '0;
      if (q2.size() > 0) f2 = q2[0]; else f2 = '0;
      cmp("m32x4", q0.size(), ov0, ir0, or0, od0, 4'(oi0), ol0, f0);
      cmp("m8x1", q1.size(), ov1, ir1, or1, 32'(od1), 4'(oi1), ol1, f1);
      cmp("m8x16", q2.size(), ov2, ir2, or2, 32'(od2), oi2, ol2, f2);
    end
  end

  task automatic expect_word(input string nm, input logic [31:0] w, input int idx,
                             input bit last);
    @(negedge clk);
    chk({nm, " valid"}, 128'(ov0), 128'(1));
    chk({nm, " data"}, 128'(od0), 128'(w));
    chk({nm, " idx"}, 128'(oi0), 128'(idx));
    chk({nm, " last"}, 128'(ol0), 128'(last));
    @(posedge clk); #1;
  endtask

  task automatic expect_idle(input string nm);
    @(negedge clk);
    chk({nm, " idle valid"}, 128'(ov0), 128'(0));
    chk({nm, " idle ready"}, 128'(ir0), 128'(1));
    @(posedge clk); #1;
  endtask

  task automatic offer(input logic [127:0] blk, input logic mode);
    iv0 = 1'b1; d0 = blk; m0 = mode;
    @(posedge clk); #1;
    iv0 = 1'b0; d0 = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Random traffic on the 8-bit configurations.
  initial begin
    iv1 = 1'b0; d1 = '0; m1 = 1'b0; or1 = 1'b1;
    iv2 = 1'b0; d2 = '0; m2 = 1'b0; or2 = 1'b1;
    wait (rst_n === 1'b1);
    @(posedge clk); #1;
    repeat (3000) begin
      iv1 = ($urandom_range(0, 2) != 0);
      d1  = 8'($urandom);
      m1  = 1'($urandom_range(0, 1));
      or1 = ($urandom_range(0, 3) != 0);
      iv2 = ($urandom_range(0, 3) != 0);
      d2  = {$urandom, $urandom, $urandom, $urandom};
      m2  = 1'($urandom_range(0, 1));
      or2 = ($urandom_range(0, 4) != 0);
      @(posedge clk); #1;
    end
    iv1 = 1'b0; iv2 = 1'b0; or1 = 1'b1; or2 = 1'b1;
    repeat (20) @(posedge clk);
    rnd_done = 1'b1;
  end

  initial begin
    int n;
    blk_a = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    blk_b = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
    aw = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    bw = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98};

    rst_n = 1'b0; iv0 = 1'b0; d0 = '0; m0 = 1'b0; or0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 128'(ov0), 128'(0));
    chk("reset out_data", 128'(od0), 128'(0));
    chk("reset out_idx", 128'(oi0), 128'(0));
    chk("reset out_last", 128'(ol0), 128'(0));
    chk("reset in_ready", 128'(ir0), 128'(1));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // MSW-first
    offer(blk_a, 1'b0);
    for (int i = 0; i < 4; i++) expect_word("msw", aw[i], i, i == 3);
    expect_idle("msw");

    // LSW-first
    offer(blk_a, 1'b1);
    for (int i = 0; i < 4; i++) expect_word("lsw", aw[3-i], 3 - i, i == 3);
    expect_idle("lsw");

    // Backpressure on word 1
    offer(blk_a, 1'b0);
    expect_word("bp", aw[0], 0, 1'b0);
    or0 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp hold valid", 128'(ov0), 128'(1));
      chk("bp hold data", 128'(od0), 128'(aw[1]));
      chk("bp hold idx", 128'(oi0), 128'(1));
      chk("bp hold in_ready", 128'(ir0), 128'(0));
      @(posedge clk); #1;
    end
    or0 = 1'b1;
    for (int i = 1; i < 4; i++) expect_word("bp", aw[i], i, i == 3);
    expect_idle("bp");

    // Back-to-back blocks with in_valid held
    iv0 = 1'b1; d0 = blk_a; m0 = 1'b0;
    @(posedge clk); #1;
    d0 = blk_b;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("b2b valid", 128'(ov0), 128'(1));
      chk("b2b data", 128'(od0), 128'((i < 4) ? aw[i] : bw[i-4]));
      chk("b2b idx", 128'(oi0), 128'(i % 4));
      chk("b2b last", 128'(ol0), 128'(i % 4 == 3));
      chk("b2b in_ready", 128'(ir0), 128'(i % 4 == 3));
      @(posedge clk); #1;
      if (i == 3) iv0 = 1'b0;
    end
    expect_idle("b2b");

    // Reset after word 1 transfers
    offer(blk_a, 1'b0);
    expect_word("rst", aw[0], 0, 1'b0);
    expect_word("rst", aw[1], 1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst async valid", 128'(ov0), 128'(0));
    chk("rst async data", 128'(od0), 128'(0));
    chk("rst async in_ready", 128'(ir0), 128'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    offer(blk_b, 1'b0);
    for (int i = 0; i < 4; i++) expect_word("post rst", bw[i], i, i == 3);

    // Random traffic on the 32x4 configuration
    repeat (1500) begin
      iv0 = ($urandom_range(0, 2) != 0);
      d0  = {$urandom, $urandom, $urandom, $urandom};
      m0  = 1'($urandom_range(0, 1));
      or0 = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    iv0 = 1'b0; or0 = 1'b1;
    repeat (8) @(posedge clk);

    n = 0;
    while (!rnd_done && n < 10000) begin
      @(posedge clk);
      n++;
    end
    if (!rnd_done) begin
      vectors++;
      errors++;
      $display("FAIL random driver timeout: got not done expected done");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
